sap_control_sequencer: RTL

- Microcoded control unit for the 8-bit bus CPU. It sequences the PC, MAR, RAM, IR, A/B registers, ALU, flags and output register over the shared 8-bit bus.
- Holds a T-state counter and a run/halt state, and decodes {opcode, step, flags} into a 16-bit control word.
- Downstream glue inverts the *_IN bits onto the registers' active-low gate enables and the *_OUT bits onto their output-enable pins.

---
 rtl/sap_ctrl_pkg.sv | 56 +++++
 rtl/sap_bus_driver_chk.sv | 20 ++
 rtl/sap_microcode_rom.sv | 73 +++++++
 rtl/sap_control_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sap_ctrl_pkg
// Shared constants for the SAP control sequencer:
//   - sequencer geometry (T-states per instruction, control word width)
//   - control word bit indices CW_HLT..CW_FI
//   - opcode encodings OP_NOP..OP_HLT
//   - run/halt state enum
//   - cw_bit(): one-hot control word helper used by the microcode decode
// -----------------------------------------------------------------------------
package sap_ctrl_pkg;

  localparam int SEQ_STEPS    = 5;
  localparam int SEQ_CW_WIDTH = 16;

  // Control word bit map
  localparam int CW_HLT = 0;
  localparam int CW_MI  = 1;
  localparam int CW_RI  = 2;
  localparam int CW_RO  = 3;
  localparam int CW_IO  = 4;
  localparam int CW_II  = 5;
  localparam int CW_AI  = 6;
  localparam int CW_AO  = 7;
  localparam int CW_EO  = 8;
  localparam int CW_SU  = 9;
  localparam int CW_BI  = 10;
  localparam int CW_OI  = 11;
  localparam int CW_CE  = 12;
  localparam int CW_CO  = 13;
  localparam int CW_J   = 14;
  localparam int CW_FI  = 15;

  // Opcodes (IR upper nibble); 0x9-0xD are unassigned and decode as NOP
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } seq_state_e;

  // Control word with only bit idx set
  function automatic logic [SEQ_CW_WIDTH-1:0] cw_bit(input int idx);
    return {{(SEQ_CW_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/sap_bus_driver_chk.sv
// -----------------------------------------------------------------------------
// sap_bus_driver_chk
// Simulation checker: at most one of RO/IO/AO/EO/CO may drive the shared bus
// in any cycle outside reset. Contains no synthesizable logic.
// Ports:
//   i_clk      clock
//   i_clr      synchronous reset (check disabled while high)
//   i_drivers  [4:0] {RO, IO, AO, EO, CO} control bits
// -----------------------------------------------------------------------------
module sap_bus_driver_chk (
  input logic       i_clk,
  input logic       i_clr,
  input logic [4:0] i_drivers
);

  a_single_bus_driver: assert property (
    @(posedge i_clk) disable iff (i_clr) ($countones(i_drivers) <= 1)
  );

endmodule

// File: rtl/sap_microcode_rom.sv
// -----------------------------------------------------------------------------
// sap_microcode_rom
// Purely combinational microcode decode {opcode, step, flags} -> control word.
// T0/T1 are the common fetch; T2..T4 are opcode specific. Flags only matter
// for JC/JZ at T2.
// Ports:
//   i_opcode    [3:0]         instruction opcode
//   i_step      [STEP_W-1:0]  T-state to decode
//   i_flag_c                  carry flag
//   i_flag_z                  zero flag
//   o_ctrl_word [CW_WIDTH-1:0] active-high control lines
// -----------------------------------------------------------------------------
module sap_microcode_rom
  import sap_ctrl_pkg::*;
#(
  parameter int STEP_W   = 3,
  parameter int CW_WIDTH = SEQ_CW_WIDTH
) (
  input  logic [3:0]          i_opcode,
  input  logic [STEP_W-1:0]   i_step,
  input  logic                i_flag_c,
  input  logic                i_flag_z,
  output logic [CW_WIDTH-1:0] o_ctrl_word
);

  logic [SEQ_CW_WIDTH-1:0] w_cw;

  // Microcode table decode
  always_comb begin
    w_cw = '0;
    case (i_step)
      STEP_W'(0): w_cw = cw_bit(CW_CO) | cw_bit(CW_MI);
      STEP_W'(1): w_cw = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
      STEP_W'(2): begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w_cw = cw_bit(CW_IO) | cw_bit(CW_MI);
          OP_LDI: w_cw = cw_bit(CW_IO) | cw_bit(CW_AI);
          OP_JMP: w_cw = cw_bit(CW_IO) | cw_bit(CW_J);
          OP_JC: begin
            if (i_flag_c) w_cw = cw_bit(CW_IO) | cw_bit(CW_J);
            else          w_cw = '0;
          end
          OP_JZ: begin
            if (i_flag_z) w_cw = cw_bit(CW_IO) | cw_bit(CW_J);
            else          w_cw = '0;
          end
          OP_OUT: w_cw = cw_bit(CW_AO) | cw_bit(CW_OI);
          OP_HLT: w_cw = cw_bit(CW_HLT);
          default: w_cw = '0;
        endcase
      end
      STEP_W'(3): begin
        case (i_opcode)
          OP_LDA:         w_cw = cw_bit(CW_RO) | cw_bit(CW_AI);
          OP_ADD, OP_SUB: w_cw = cw_bit(CW_RO) | cw_bit(CW_BI);
          OP_STA:         w_cw = cw_bit(CW_AO) | cw_bit(CW_RI);
          default:        w_cw = '0;
        endcase
      end
      STEP_W'(4): begin
        case (i_opcode)
          OP_ADD:  w_cw = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
          OP_SUB:  w_cw = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI) | cw_bit(CW_SU);
          default: w_cw = '0;
        endcase
      end
      default: w_cw = '0;
    endcase
  end

  assign o_ctrl_word = CW_WIDTH'(w_cw);

endmodule

// File: rtl/sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer
// Control unit for the 8-bit bus CPU: T-state counter plus RUN/HALT state,
// feeding sap_microcode_rom to produce the 16-bit control word.
// Optional feature macro: SAP_SEQ_EARLY_END_EN -- when defined, an
// instruction returns to T0 as soon as its next execute step (>= T2) would
// decode to an all-zero word (HLT excluded).
// Ports:
//   CLK        system clock, posedge
//   CLR        synchronous active-high reset (priority over step_en)
//   step_en    sequencer clock enable (low freezes step/state)
//   opcode     [3:0] IR upper nibble, stable from T2 onward
//   flag_c     latched carry flag
//   flag_z     latched zero flag
//   ctrl_word  [CW_WIDTH-1:0] active-high control lines, 0 during CLR/HALT
//   step       [2:0] current T-state (zero-extended)
//   halted     high in HALT state
// -----------------------------------------------------------------------------
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int STEPS    = SEQ_STEPS,
  parameter int CW_WIDTH = SEQ_CW_WIDTH
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                step_en,
  input  logic [3:0]          opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  output logic [CW_WIDTH-1:0] ctrl_word,
  output logic [2:0]          step,
  output logic                halted
);

  localparam int STEP_W = $clog2(STEPS);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_HLT  = STEP_W'(2);  // T-state carrying HLT
  localparam logic [STEP_W-1:0] STEP_PARK = STEP_W'(3);  // step value while halted

  logic [STEP_W-1:0]   r_step;
  seq_state_e          r_state;
  logic [STEP_W-1:0]   w_step_inc;
  logic [STEP_W-1:0]   w_step_next;
  logic [CW_WIDTH-1:0] w_cw_rom;

  sap_microcode_rom #(.STEP_W(STEP_W), .CW_WIDTH(CW_WIDTH)) u_rom (
    .i_opcode    (opcode),
    .i_step      (r_step),
    .i_flag_c    (flag_c),
    .i_flag_z    (flag_z),
    .o_ctrl_word (w_cw_rom)
  );

  // Plain modulo-STEPS increment
  always_comb begin
    if (r_step == STEP_LAST) w_step_inc = '0;
    else                     w_step_inc = r_step + STEP_W'(1);
  end

`ifdef SAP_SEQ_EARLY_END_EN
  logic [CW_WIDTH-1:0] w_cw_peek;

  // Flags are tied high here so a conditional jump always runs its T2; the
  // real flag decision is made by the main decode while T2 is current.
  sap_microcode_rom #(.STEP_W(STEP_W), .CW_WIDTH(CW_WIDTH)) u_rom_peek (
    .i_opcode    (opcode),
    .i_step      (w_step_inc),
    .i_flag_c    (1'b1),
    .i_flag_z    (1'b1),
    .o_ctrl_word (w_cw_peek)
  );

  // Skip the zero-word tail of an instruction
  always_comb begin
    if ((w_step_inc >= STEP_W'(2)) && (w_cw_peek == '0) && (opcode != OP_HLT))
      w_step_next = '0;
    else
      w_step_next = w_step_inc;
  end
`else
  // Every instruction runs the full STEPS T-states
  always_comb begin
    w_step_next = w_step_inc;
  end
`endif

  // Step counter and RUN/HALT state machine
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_step  <= '0;
      r_state <= S_RUN;
    end else if (r_state == S_HALT) begin
      r_step  <= STEP_PARK;
      r_state <= S_HALT;
    end else if (step_en) begin
      if ((r_step == STEP_HLT) && (opcode == OP_HLT)) begin
        r_step  <= STEP_PARK;
        r_state <= S_HALT;
      end else begin
        r_step  <= w_step_next;
        r_state <= S_RUN;
      end
    end else begin
      r_step  <= r_step;
      r_state <= r_state;
    end
  end

  // CLR blanks the word in the same cycle, before the counter has reset
  always_comb begin
    if (CLR || (r_state == S_HALT)) ctrl_word = '0;
    else                            ctrl_word = w_cw_rom;
  end

  assign step   = 3'(r_step);
  assign halted = (r_state == S_HALT);

  sap_bus_driver_chk u_bus_chk (
    .i_clk     (CLK),
    .i_clr     (CLR),
    .i_drivers ({ctrl_word[CW_RO], ctrl_word[CW_IO], ctrl_word[CW_AO],
                 ctrl_word[CW_EO], ctrl_word[CW_CO]})
  );

endmodule
